// File: rtl/data_memory_hs.sv
// data_memory_hs: handshake data memory with byte/half/word access, sign/zero-extended loads,
// configurable response latency and a hardware clear sequence after reset.
module data_memory_hs #(
    parameter int MEM_DEPTH  = 16384,
    parameter int LATENCY    = 1,
    parameter bit INIT_CLEAR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_done
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {START, CLEAR, IDLE, WAIT} state_t;

    state_t        state, nxt;
    logic [31:0]   mem [MEM_DEPTH];
    logic [AW-1:0] clr_idx, idx;
    logic [3:0]    cnt, be;
    logic [1:0]    lane;
    logic          accept, err, pend_err, done_wait, unused_addr;
    logic [31:0]   wword, shifted, load_val, pend_rdata;

    assign idx         = req_addr[AW+1:2];
    assign lane        = req_addr[1:0];
    assign unused_addr = ^req_addr[31:AW+2];
    assign req_ready   = state == IDLE;
    assign accept      = req_valid && req_ready;
    assign done_wait   = state == WAIT && cnt == 4'd0;
    assign err = req_size == 2'b11 || (req_size == 2'b01 && lane[0]) ||
                 (req_size == 2'b10 && lane != 2'b00);

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    assign be = !accept || !req_write || err ? 4'b0000 :
                req_size == 2'b00 ? 4'b0001 << lane :
                req_size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wword = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                   req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;

    assign shifted  = mem[idx] >> {lane, 3'b000};
    assign load_val = req_size == 2'b00 ? {{24{!req_unsigned && shifted[7]}}, shifted[7:0]} :
                      req_size == 2'b01 ? {{16{!req_unsigned && shifted[15]}}, shifted[15:0]} :
                      shifted;

    always_comb begin
        nxt = state;
        case (state)
            START:   nxt = INIT_CLEAR ? CLEAR : IDLE;
            CLEAR:   nxt = clr_idx == AW'(MEM_DEPTH - 1) ? IDLE : CLEAR;
            IDLE:    nxt = accept ? WAIT : IDLE;
            WAIT:    nxt = cnt == 4'd0 ? IDLE : WAIT;
            default: nxt = START;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= START;
            clr_idx    <= '0;
            cnt        <= '0;
            pend_rdata <= '0;
            pend_err   <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state      <= nxt;
            init_done  <= init_done || nxt == IDLE;
            resp_valid <= done_wait;
            if (state == CLEAR)
                clr_idx <= clr_idx + 1'b1;
            if (accept) begin
                cnt        <= 4'(LATENCY - 1);
                pend_err   <= err;
                pend_rdata <= err || req_write ? '0 : load_val;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 1'b1;
            end
            if (done_wait) begin
                resp_rdata <= pend_rdata;
                resp_err   <= pend_err;
            end
        end
    end

    // The array has no reset; while reset is low the state is START, so nothing writes.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_idx] <= '0;
        for (int i = 0; i < 4; i++)
            if (be[i])
                mem[idx][8*i +: 8] <= wword[8*i +: 8];
    end
endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs: randomized and directed requests against a byte-array reference model,
// with responses checked by a scoreboard monitor for data, error flag and arrival cycle.
module tb_data_memory_hs;
    localparam int MEM_DEPTH = 64;
    localparam int LATENCY   = 3;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, resp_valid, resp_err, init_done;
    logic [31:0] resp_rdata;

    logic [7:0]  model [MEM_DEPTH*4];
    exp_t        sbq [$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    data_memory_hs #(.MEM_DEPTH(MEM_DEPTH), .LATENCY(LATENCY), .INIT_CLEAR(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .init_done(init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && resp_valid) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b expected no response", resp_rdata, resp_err);
            end else begin
                e = sbq.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic scramble();
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_write    = 1'($urandom);
        req_unsigned = 1'($urandom);
    endtask

    // Issues one request; the expected response comes from the byte-array model unless overridden.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic u,
                          input bit use_exp = 0, input logic [31:0] exp_v = 0);
        int n = 0;
        int b;
        bit err;
        logic [31:0] v = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 100 cycles");
            return;
        end
        err = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        b = int'((a >> 2) % MEM_DEPTH) * 4 + int'(a[1:0]);
        if (!err) begin
            for (int i = 0; i < (1 << sz); i++)
                if (w) model[b+i] = wd[8*i +: 8];
                else   v |= 32'(model[b+i]) << (8*i);
            if (!w && !u && sz == 2'd0 && v[7])  v |= 32'hFFFFFF00;
            if (!w && !u && sz == 2'd1 && v[15]) v |= 32'hFFFF0000;
        end
        e.err   = err;
        e.rdata = use_exp ? exp_v : v;
        e.due   = cyc + 1 + LATENCY;
        sbq.push_back(e);
        req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble();
    endtask

    // Asserts reset (asynchronous), checks outputs, then times the clear sequence
    // while offering a store that must be ignored.
    task automatic do_reset();
        int n = 0;
        reset = 1'b0;
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        sbq.delete();
        for (int i = 0; i < MEM_DEPTH*4; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
        req_addr = $urandom & 32'hFFFF_FFFC; req_wdata = 32'hA5A5_5A5A;
        reset = 1'b1;
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("clear_cycles", 32'(n), 32'(MEM_DEPTH + 1));
        chk("init_done", {31'd0, init_done}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        #2;
        do_reset();
        do_req(0, 32'h00, 0, 2, 0, 1, 32'h0);
        do_req(0, 32'h7C, 0, 2, 0, 1, 32'h0);
        do_req(0, 32'h100, 0, 2, 0, 1, 32'h0);
        do_req(1, 32'h10, 32'hDEADBEEF, 2, 0);
        do_req(0, 32'h10, 0, 2, 0, 1, 32'hDEADBEEF);
        do_req(1, 32'h20, 32'hFFFFFFFF, 2, 0);
        do_req(1, 32'h21, 32'h00000011, 0, 0);
        do_req(1, 32'h22, 32'h0000A5B6, 1, 0);
        do_req(0, 32'h20, 0, 2, 0, 1, 32'hA5B611FF);
        do_req(1, 32'h30, 32'h80FF7F01, 2, 0);
        do_req(0, 32'h32, 0, 0, 0, 1, 32'hFFFFFFFF);
        do_req(0, 32'h33, 0, 0, 1, 1, 32'h00000080);
        do_req(0, 32'h30, 0, 1, 0, 1, 32'h00007F01);
        do_req(0, 32'h32, 0, 1, 0, 1, 32'hFFFF80FF);
        do_req(1, 32'h40, 32'h12345678, 2, 0);
        do_req(1, 32'h41, 32'h0000BEEF, 1, 0);
        do_req(0, 32'h40, 0, 2, 0, 1, 32'h12345678);
        do_req(0, 32'h42, 0, 2, 0);
        do_req(0, 32'h44, 0, 3, 0);
        for (int k = 0; k < 200; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3)
                a = a & ~((32'd1 << sz) - 32'd1);
            do_req(1'($urandom), a, $urandom, sz, 1'($urandom));
        end
        drain();
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        do_reset();
        for (int w = 0; w < MEM_DEPTH; w++)
            do_req(0, 32'(w * 4), 0, 2, 0, 1, 32'h0);
        drain();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_memory_hs.md
# data_memory_hs

Parametrised, handshake-based data memory for the pipelined CPU's MEM stage: the successor to the single-cycle word-only data memory. It adds byte/halfword/word stores with lane enables, sign/zero-extended loads and misalignment detection. It has configurable access latency and a hardware clear sequence after reset. One request is outstanding at a time; the pipeline stalls on `req_ready`.

## Interface
- `MEM_DEPTH`, default 16384: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, default 1: cycles from acceptance to response; legal range 1..16.
- `INIT_CLEAR`, default 1: 1 = zero the whole array after reset; 0 = skip the clear, contents undefined.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `resp_valid` out 1: one-cycle response pulse; there is no back-pressure.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal-size request; qualified by `resp_valid`.
- `init_done` out 1: clear sequence finished (or skipped).

## Operation
- States: START, CLEAR, IDLE, WAIT.
  - `reset` low forces START, counters to 0 and all outputs to 0.
  - START → CLEAR (INIT_CLEAR=1) or IDLE (INIT_CLEAR=0) on the first edge after release.
- CLEAR writes word `clr_idx` = 0 and increments `clr_idx`, one word per edge.
  - After writing index MEM_DEPTH-1 → IDLE; `init_done` goes 1 and stays 1 until reset.
- `req_ready` = 1 only in IDLE. A request is accepted on an edge where `req_valid && req_ready`.
- Word index = `req_addr[31:2]` mod MEM_DEPTH; upper bits are ignored and the index wraps.
- Lane = `req_addr[1:0]`, little-endian.
- Error conditions:
  - size 11;
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
  - On error: no array write, `resp_err`=1, `resp_rdata`=0.
- Store commits at the acceptance edge, writing only the addressed lanes:
  - byte: lane `addr[1:0]` ← `wdata[7:0]`;
  - half: lanes {`addr[1]`*2+1, `addr[1]`*2} ← `wdata[15:0]`;
  - word: all four lanes.
  - Other lanes are unchanged.
- Load samples the array at the acceptance edge. The selected byte or half is extended to 32 bits per `req_unsigned`. The result is held in a response register.
- On acceptance → WAIT with `cnt` = LATENCY-1. Each WAIT edge:
  - if `cnt`=0 → IDLE, and `resp_valid`, `resp_err`, `resp_rdata` are loaded;
  - else `cnt` decrements.
- `resp_valid` is cleared on the next edge unless another response completes.
- `resp_rdata`/`resp_err` hold their last values when `resp_valid`=0.
- Reset mid-WAIT drops the pending response. A store accepted before the reset edge remains committed; with INIT_CLEAR=1 it is then zeroed by CLEAR.
- `req_*` inputs are ignored when not accepted, including in CLEAR, WAIT and START.

## Timing
- Acceptance at edge E. The response is visible in the cycle after edge E+LATENCY. `req_ready`=1 in that same cycle, so the next request can be accepted at edge E+LATENCY+1.
- Throughput: one request per LATENCY+1 cycles.
- Read-after-write is coherent: a load accepted after a store sees the store's data.
- Clear duration: `init_done` rises after edge MEM_DEPTH+1 counted from reset release (INIT_CLEAR=1). With INIT_CLEAR=0 it rises after edge 1.
- All outputs are registered, except `req_ready`, which is decoded from the state register.

## Test plan
- Clear: MEM_DEPTH=64, INIT_CLEAR=1.
  - Pre-load garbage, pulse `reset` low, release → `req_ready`=0 for 65 cycles, then `init_done`=1.
  - Word loads of 0x00, 0x7C, 0x100 (wraps to 0) → 0.
- Latency: LATENCY=3. Store word 0xDEADBEEF @0x10 at edge E → `resp_valid` only in the cycle after E+3, `resp_err`=0. Load @0x10 accepted at E+4 → `resp_rdata`=0xDEADBEEF after E+7.
- Sub-word stores: byte 0x11 @0x21 and half 0xA5B6 @0x22 into a word pre-set to 0xFFFFFFFF → word load @0x20 = 0xA5B611FF.
- Extension, using word 0x80FF7F01 @0x30:
  - signed byte @0x32 → 0xFFFFFFFF;
  - unsigned byte @0x33 → 0x00000080;
  - signed half @0x30 → 0x00007F01;
  - signed half @0x32 → 0xFFFF80FF.
- Errors:
  - half store @0x41 → `resp_err`=1 and the memory at 0x40 is unchanged;
  - word load @0x42 → `resp_err`=1, `rdata`=0;
  - size 11 → `resp_err`=1.
- Reset mid-op: accept a load, assert `reset` in WAIT → `resp_valid`=0 and all outputs are 0 immediately (asynchronous); no response pulse is produced after release.
